// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage.
package wb_pkg;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } hold_state_e;

endpackage

// File: rtl/wb_load_hold.sv
// Keeps BRAM load data stable while a load sits stalled in WB.
// BRAM douta is only valid the cycle after the read, so the first stalled
// cycle snapshots it and later stalled cycles replay the snapshot.
module wb_load_hold
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              load_in_wb,
  input  logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] load_data
);

  hold_state_e       state_q, state_d;
  logic [DATA_W-1:0] ld_hold;

  // State register and snapshot of douta on entry to HELD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LIVE;
      ld_hold <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == LIVE && load_in_wb && stall) ld_hold <= mem_result;
    end
  end

  // Next state and load data selection
  always_comb begin
    state_d   = state_q;
    load_data = mem_result;
    case (state_q)
      LIVE: if (load_in_wb && stall) state_d = HELD;
      HELD: begin
        load_data = ld_hold;
        if (!stall) state_d = LIVE;
      end
      default: state_d = LIVE;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, register-file write port
// and retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              mem_valid,
  input  logic              mem_re,
  input  logic              mem_reg_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_ALU_select,
  input  logic [DATA_W-1:0] sprite_ALU_result,
  input  logic [DATA_W-1:0] mem_result,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  typedef struct packed {
    logic              valid;
    logic              re;     // debug visibility only; sel drives the mux
    logic              we;
    logic [REG_AW-1:0] rd;
    logic              sel;
    logic [DATA_W-1:0] alu;
  } wb_req_t;

  wb_req_t           stg_q;
  logic [DATA_W-1:0] load_data;
  logic              retire;

  // MEM/WB boundary; reset wins over stall
  always_ff @(posedge clk) begin
    if (rst)        stg_q <= '0;
    else if (!stall) begin
      stg_q.valid <= mem_valid;
      stg_q.re    <= mem_re;
      stg_q.we    <= mem_reg_we;
      stg_q.rd    <= mem_rd;
      stg_q.sel   <= mem_ALU_select;
      stg_q.alu   <= sprite_ALU_result;
    end
  end

  wb_load_hold #(.DATA_W(DATA_W)) u_load_hold (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .load_in_wb (stg_q.valid & (stg_q.sel == WB_SEL_MEM)),
    .mem_result (mem_result),
    .load_data  (load_data)
  );

  // An instruction retires in the single WB cycle where it is not stalled
  assign retire  = stg_q.valid & ~stall;
  assign wb_we   = retire & stg_q.we & (stg_q.rd != REG_AW'(REG_ZERO));
  assign wb_addr = stg_q.rd;
  assign wb_data = (stg_q.sel == WB_SEL_MEM) ? load_data : stg_q.alu;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)         retire_count <= '0;
    else if (retire) retire_count <= retire_count + 1'b1;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: inputs change 1ns after a rising edge,
// outputs are checked after that settle time.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, mem_valid, mem_re, mem_reg_we, mem_ALU_select;
  logic [4:0]  mem_rd;
  logic [31:0] sprite_ALU_result, mem_result;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, retire_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .mem_valid(mem_valid),
    .mem_re(mem_re), .mem_reg_we(mem_reg_we), .mem_rd(mem_rd),
    .mem_ALU_select(mem_ALU_select), .sprite_ALU_result(sprite_ALU_result),
    .mem_result(mem_result), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .retire_count(retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb(input string tag, input logic we, input logic [4:0] addr,
                    input logic [31:0] data, input logic [31:0] cnt);
    chk({tag, ".we"},   {31'd0, wb_we}, {31'd0, we});
    chk({tag, ".addr"}, {27'd0, wb_addr}, {27'd0, addr});
    chk({tag, ".data"}, wb_data, data);
    chk({tag, ".cnt"},  retire_count, cnt);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic re, input logic we, input logic [4:0] rd,
                       input logic sel, input logic [31:0] alu);
    mem_valid = v; mem_re = re; mem_reg_we = we; mem_rd = rd;
    mem_ALU_select = sel; sprite_ALU_result = alu;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; mem_result = 32'h0;
    drive(1, 0, 1, 5'd3, 0, 32'hFFFF_FFFF);
    // Reset with a valid instruction presented
    edge1(); wb("rst0", 0, 5'd0, 32'h0, 32'd0);
    edge1(); wb("rst1", 0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0; drive(0, 0, 0, 5'd0, 0, 32'h0);
    edge1(); wb("post_rst", 0, 5'd0, 32'h0, 32'd0);

    // ALU writeback
    drive(1, 0, 1, 5'd5, 0, 32'h1234_5678);
    edge1(); wb("alu", 1, 5'd5, 32'h1234_5678, 32'd0);

    // Load, douta valid the cycle it is in WB
    drive(1, 1, 1, 5'd7, 1, 32'h0);
    edge1(); mem_result = 32'hDEAD_BEEF; #1;
    wb("load", 1, 5'd7, 32'hDEAD_BEEF, 32'd1);

    // Stalled load; a new ALU op arrives under stall and must not be taken
    drive(1, 1, 1, 5'd9, 1, 32'h0);
    edge1(); stall = 1'b1; mem_result = 32'hDEAD_BEEF;
    drive(1, 0, 1, 5'd10, 0, 32'h0000_AAAA); #1;
    wb("stl_ld0", 0, 5'd9, 32'hDEAD_BEEF, 32'd2);
    edge1(); mem_result = 32'h0; #1;
    wb("stl_ld1", 0, 5'd9, 32'hDEAD_BEEF, 32'd2);
    edge1(); wb("stl_ld2", 0, 5'd9, 32'hDEAD_BEEF, 32'd2);
    stall = 1'b0; #1;
    wb("stl_rel", 1, 5'd9, 32'hDEAD_BEEF, 32'd2);

    // ALU op now in WB; stall it
    edge1(); wb("alu10", 1, 5'd10, 32'h0000_AAAA, 32'd3);
    stall = 1'b1; #1;
    wb("alu_stl0", 0, 5'd10, 32'h0000_AAAA, 32'd3);
    edge1(); wb("alu_stl1", 0, 5'd10, 32'h0000_AAAA, 32'd3);
    stall = 1'b0; #1;
    wb("alu_rel", 1, 5'd10, 32'h0000_AAAA, 32'd3);

    // r0 write suppressed but counted; bubble neither writes nor counts
    drive(1, 0, 1, 5'd0, 0, 32'h77);
    edge1(); wb("r0", 0, 5'd0, 32'h77, 32'd4);
    drive(0, 0, 1, 5'd6, 0, 32'h66);
    edge1(); wb("bub0", 0, 5'd6, 32'h66, 32'd5);
    edge1(); wb("bub1", 0, 5'd6, 32'h66, 32'd5);

    // Back-to-back loads stay LIVE
    drive(1, 1, 1, 5'd11, 1, 32'h0);
    edge1(); mem_result = 32'h1111_1111; drive(1, 1, 1, 5'd12, 1, 32'h0); #1;
    wb("ld11", 1, 5'd11, 32'h1111_1111, 32'd5);
    edge1(); mem_result = 32'h2222_2222; drive(1, 1, 1, 5'd13, 1, 32'h0); #1;
    wb("ld12", 1, 5'd12, 32'h2222_2222, 32'd6);

    // Reset while HELD, with stall still high
    edge1(); mem_result = 32'hCAFE_F00D; stall = 1'b1; #1;
    wb("ld13", 0, 5'd13, 32'hCAFE_F00D, 32'd7);
    edge1(); mem_result = 32'h0; #1;
    wb("ld13_held", 0, 5'd13, 32'hCAFE_F00D, 32'd7);
    rst = 1'b1;
    edge1(); wb("rst_held", 0, 5'd0, 32'h0, 32'd0);
    rst = 1'b0; stall = 1'b0;
    drive(1, 0, 1, 5'd2, 0, 32'h55);
    edge1(); wb("alu2", 1, 5'd2, 32'h55, 32'd0);
    // Load after reset must see live douta, not a stale snapshot
    drive(1, 1, 1, 5'd14, 1, 32'h0);
    edge1(); mem_result = 32'h3C; drive(0, 0, 0, 5'd0, 0, 32'h0); #1;
    wb("ld14", 1, 5'd14, 32'h3C, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
